// File: rtl/hazard_sb_pkg.sv
// Shared types, constants and the register-match helper for the hazard unit.
// Everything here is independent of the HAZARD_MC_EN build option.
package hazard_pkg;

  localparam int RW_MAX = 8;
  localparam int FW_MAX = 4;

  typedef logic [FW_MAX-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = fwd_sel_t'(0);
  localparam fwd_sel_t FWD_M  = fwd_sel_t'(1);

  localparam int MC_LAT_MIN = 2;

  // x0 is hard-wired to zero in RISC-V mode, so it never creates a dependency there.
  function automatic logic reg_match(input logic [RW_MAX-1:0] a,
                                     input logic [RW_MAX-1:0] b,
                                     input logic              arm);
    return (a == b) && (arm || (a != '0));
  endfunction

endpackage

// File: rtl/hazard_sb_mc_scoreboard.sv
// Scoreboard for the single non-pipelined multi-cycle unit: latency counter,
// in-flight destination, latency clamp and the D-stage stall compare.
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NREG   = 32,
  parameter  int MAXLAT = 16,
  localparam int RW     = $clog2(NREG),
  localparam int LW     = $clog2(MAXLAT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          arm_i,
  input  logic          mc_start_i,
  input  logic [LW-1:0] mc_lat_i,
  input  logic [RW-1:0] mc_rd_i,
  input  logic          mc_op_d_i,
  input  logic [RW-1:0] rs1_d_i,
  input  logic [RW-1:0] rs2_d_i,
  input  logic [RW-1:0] rd_d_i,
  output logic          busy_o,
  output logic          wb_o,
  output logic [RW-1:0] rd_o,
  output logic          stall_o
);

  logic [LW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [LW-1:0] lat_clamped;
  logic          hazard;

  always_comb begin
    lat_clamped = mc_lat_i;
    if (mc_lat_i < LW'(MC_LAT_MIN)) begin
      lat_clamped = LW'(MC_LAT_MIN);
    end else if (mc_lat_i > LW'(MAXLAT)) begin
      lat_clamped = LW'(MAXLAT);
    end
  end

  // A new issue always wins, even over an op still in flight.
  always_comb begin
    cnt_d = cnt_q;
    rd_d  = rd_q;
    if (mc_start_i) begin
      cnt_d = lat_clamped;
      rd_d  = mc_rd_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      rd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign wb_o   = (cnt_q == LW'(1));
  assign rd_o   = rd_q;

  assign hazard = mc_op_d_i
                | reg_match(RW_MAX'(rs1_d_i), RW_MAX'(rd_q), arm_i)
                | reg_match(RW_MAX'(rs2_d_i), RW_MAX'(rd_q), arm_i)
                | reg_match(RW_MAX'(rd_d_i),  RW_MAX'(rd_q), arm_i);

  // In the writeback cycle the write-first regfile bypass serves D and the unit
  // is free by the time the D instruction reaches E, so the stall drops at cnt == 1.
  assign stall_o = (cnt_q > LW'(1)) & hazard;

endmodule

// File: rtl/hazard_sb.sv
// Hazard unit for the ARM/RISC-V five-stage pipeline: N-stage forwarding, load-use,
// PC-write and branch control. Define HAZARD_MC_EN to build the multi-cycle scoreboard.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter  int NREG   = 32,
  parameter  int NFWD   = 2,
  parameter  int MAXLAT = 16,
  localparam int RW     = $clog2(NREG),
  localparam int LW     = $clog2(MAXLAT + 1),
  localparam int FSW    = $clog2(NFWD + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     arm,
  input  logic [NFWD-1:0]          RegWriteS,
  input  logic [NFWD-1:0][RW-1:0]  RdS,
  input  logic [RW-1:0]            Rs1D,
  input  logic [RW-1:0]            Rs2D,
  input  logic [RW-1:0]            RdD,
  input  logic [RW-1:0]            Rs1E,
  input  logic [RW-1:0]            Rs2E,
  input  logic [RW-1:0]            RdE,
  input  logic [1:0]               ResultSrcE,
  input  logic                     RVPCSrcE,
  input  logic                     PCSrcD,
  input  logic                     PCSrcE,
  input  logic                     PCSrcM,
  input  logic                     PCSrcW,
  input  logic                     BranchTakenE,
  input  logic                     McOpD,
  input  logic                     McStartE,
  input  logic [LW-1:0]            McLatE,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic [FSW-1:0]           ForwardAE,
  output logic [FSW-1:0]           ForwardBE,
  output logic                     McBusy,
  output logic                     McWb,
  output logic [RW-1:0]            McRd
);

  logic [NFWD-1:0] hit_a, hit_b;
  logic            ld_stall, mc_stall, pc_wr_pending;
  logic            unused_rsrc;

  genvar gi;
  generate
    for (gi = 0; gi < NFWD; gi++) begin : g_fwd_hit
      assign hit_a[gi] = RegWriteS[gi] & reg_match(RW_MAX'(Rs1E), RW_MAX'(RdS[gi]), arm);
      assign hit_b[gi] = RegWriteS[gi] & reg_match(RW_MAX'(Rs2E), RW_MAX'(RdS[gi]), arm);
    end
  endgenerate

  // Walk from oldest to nearest so the nearest matching stage is the last writer.
  always_comb begin
    ForwardAE = FSW'(FWD_RF);
    ForwardBE = FSW'(FWD_RF);
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (hit_a[k]) ForwardAE = FSW'(FWD_M) + FSW'(k);
      if (hit_b[k]) ForwardBE = FSW'(FWD_M) + FSW'(k);
    end
  end

  assign ld_stall = ResultSrcE[0]
                  & (reg_match(RW_MAX'(Rs1D), RW_MAX'(RdE), arm)
                   | reg_match(RW_MAX'(Rs2D), RW_MAX'(RdE), arm));
  assign unused_rsrc = ResultSrcE[1];

  assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

`ifdef HAZARD_MC_EN
  mc_scoreboard #(
    .NREG   (NREG),
    .MAXLAT (MAXLAT)
  ) u_mc_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .arm_i      (arm),
    .mc_start_i (McStartE),
    .mc_lat_i   (McLatE),
    .mc_rd_i    (RdE),
    .mc_op_d_i  (McOpD),
    .rs1_d_i    (Rs1D),
    .rs2_d_i    (Rs2D),
    .rd_d_i     (RdD),
    .busy_o     (McBusy),
    .wb_o       (McWb),
    .rd_o       (McRd),
    .stall_o    (mc_stall)
  );
`else
  logic unused_mc;
  assign unused_mc = ^{clk, reset_n, McOpD, McStartE, McLatE, RdD};
  assign McBusy    = 1'b0;
  assign McWb      = 1'b0;
  assign McRd      = '0;
  assign mc_stall  = 1'b0;
`endif

  // Flush and stall may both be high on D; the pipeline register gives flush priority.
  assign StallD = ld_stall | mc_stall;
  assign StallF = ld_stall | mc_stall | (arm & pc_wr_pending);
  assign FlushE = ld_stall | mc_stall | (arm & BranchTakenE) | (~arm & RVPCSrcE);
  assign FlushD = (arm & (pc_wr_pending | PCSrcW | BranchTakenE)) | (~arm & RVPCSrcE);

endmodule

// File: tb/tb_hazard_sb.sv
// Scoreboard bench for hazard_sb: stimulus queues expected outputs, a monitor
// pops and compares them at the falling edge. Expectations follow HAZARD_MC_EN.
module tb_hazard_sb;

`ifdef HAZARD_MC_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            arm;
  logic [1:0]      RegWriteS;
  logic [1:0][4:0] RdS;
  logic [4:0]      Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
  logic [1:0]      ResultSrcE;
  logic            RVPCSrcE, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic            McOpD, McStartE;
  logic [4:0]      McLatE;
  logic            StallF, StallD, FlushD, FlushE;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            McBusy, McWb;
  logic [4:0]      McRd;

  hazard_sb dut (
    .clk(clk), .reset_n(reset_n), .arm(arm),
    .RegWriteS(RegWriteS), .RdS(RdS),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .RVPCSrcE(RVPCSrcE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE),
    .McOpD(McOpD), .McStartE(McStartE), .McLatE(McLatE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .McBusy(McBusy), .McWb(McWb), .McRd(McRd)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  sf, sd, fd, fe;
    int    fa, fb;
    logic  busy, wb;
    int    rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m = MC_EN;

  task automatic cmp(input string n, input string f, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s %s actual=%0d required=%0d", n, f, act, req);
    end
  endtask

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n && McStartE && McBusy) begin
      errors++;
      $display("FAIL illegal_issue McStartE while McBusy at %0t", $time);
    end
    if (exp_q.size() > 0) begin
      exp_t e;
      int   e0;
      e  = exp_q.pop_front();
      e0 = errors;
      cmp(e.name, "StallF",    int'(StallF),    int'(e.sf));
      cmp(e.name, "StallD",    int'(StallD),    int'(e.sd));
      cmp(e.name, "FlushD",    int'(FlushD),    int'(e.fd));
      cmp(e.name, "FlushE",    int'(FlushE),    int'(e.fe));
      cmp(e.name, "ForwardAE", int'(ForwardAE), e.fa);
      cmp(e.name, "ForwardBE", int'(ForwardBE), e.fb);
      cmp(e.name, "McBusy",    int'(McBusy),    int'(e.busy));
      cmp(e.name, "McWb",      int'(McWb),      int'(e.wb));
      cmp(e.name, "McRd",      int'(McRd),      e.rd);
      $display("t=%0t vec %s errs %0d", $time, e.name, errors - e0);
    end
  end

  task automatic chk(input string n, input logic sf, input logic sd, input logic fd,
                     input logic fe, input int fa, input int fb, input logic busy,
                     input logic wb, input int rd);
    exp_t e;
    e.name = n; e.sf = sf; e.sd = sd; e.fd = fd; e.fe = fe;
    e.fa = fa; e.fb = fb; e.busy = busy; e.wb = wb; e.rd = rd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    arm = 1'b0; RegWriteS = '0; RdS = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0; Rs1E = '0; Rs2E = '0; RdE = '0;
    ResultSrcE = '0; RVPCSrcE = 0; PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchTakenE = 0; McOpD = 0; McStartE = 0; McLatE = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, cnt;
    reset_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    chk("reset", 0,0,0,0, 0,0, 0,0, 0);
    reset_n = 1'b1;
    chk("after_reset", 0,0,0,0, 0,0, 0,0, 0);

    // Forwarding
    RegWriteS = 2'b11; RdS[0] = 5; RdS[1] = 5; Rs1E = 5;
    chk("fwd_m_priority", 0,0,0,0, 1,0, 0,0, 0);
    Rs1E = 0; RdS[0] = 0; RdS[1] = 0;
    chk("fwd_x0_rv", 0,0,0,0, 0,0, 0,0, 0);
    arm = 1'b1;
    chk("fwd_x0_arm", 0,0,0,0, 1,1, 0,0, 0);
    idle(); RegWriteS = 2'b10; RdS[0] = 6; RdS[1] = 6; Rs2E = 6;
    chk("fwd_w_only", 0,0,0,0, 0,2, 0,0, 0);
    RegWriteS = 2'b11; RdS[0] = 7; RdS[1] = 6; Rs1E = 7; Rs2E = 6;
    chk("fwd_split", 0,0,0,0, 1,2, 0,0, 0);

    // Load-use
    idle(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    chk("load_use", 1,1,0,1, 0,0, 0,0, 0);
    ResultSrcE = 2'b10;
    chk("not_load", 0,0,0,0, 0,0, 0,0, 0);
    ResultSrcE = 2'b01; RdE = 0; Rs2D = 0; Rs1D = 0;
    chk("load_x0_rv", 0,0,0,0, 0,0, 0,0, 0);

    // Control flow
    idle(); arm = 1'b1; PCSrcE = 1;
    chk("arm_pcsrce", 1,0,1,0, 0,0, 0,0, 0);
    PCSrcE = 0; BranchTakenE = 1;
    chk("arm_branch", 0,0,1,1, 0,0, 0,0, 0);
    BranchTakenE = 0; PCSrcW = 1;
    chk("arm_pcsrcw", 0,0,1,0, 0,0, 0,0, 0);
    idle(); PCSrcD = 1;
    chk("rv_ignores_pcsrc", 0,0,0,0, 0,0, 0,0, 0);
    idle(); RVPCSrcE = 1;
    chk("rv_branch", 0,0,1,1, 0,0, 0,0, 0);

    // Multi-cycle RAW, latency 4
    idle(); McStartE = 1; RdE = 9; McLatE = 4;
    chk("raw_issue", 0,0,0,0, 0,0, 0,0, 0);
    idle(); Rs1D = 9;
    for (int i = 0; i < 4; i++) begin
      cnt = 4 - i;
      st  = int'(m && cnt > 1);
      chk($sformatf("raw_c%0d", i + 1), st[0], st[0], 0, st[0], 0,0, m, m && cnt == 1, m ? 9 : 0);
    end
    chk("raw_done", 0,0,0,0, 0,0, 0,0, m ? 9 : 0);

    // Structural and WAW
    idle(); McStartE = 1; RdE = 12; McLatE = 3;
    chk("st_issue", 0,0,0,0, 0,0, 0,0, m ? 9 : 0);
    idle(); McOpD = 1;
    chk("structural", m,m,0,m, 0,0, m,0, m ? 12 : 0);
    McOpD = 0; RdD = 12;
    chk("waw", m,m,0,m, 0,0, m,0, m ? 12 : 0);
    chk("waw_wb_release", 0,0,0,0, 0,0, m,m, m ? 12 : 0);
    chk("st_done", 0,0,0,0, 0,0, 0,0, m ? 12 : 0);

    // RISC-V branch coinciding with a scoreboard stall
    idle(); McStartE = 1; RdE = 13; McLatE = 2;
    chk("fl_issue", 0,0,0,0, 0,0, 0,0, m ? 12 : 0);
    idle(); Rs2D = 13; RVPCSrcE = 1;
    chk("flush_over_stall", m,m,1,1, 0,0, m,0, m ? 13 : 0);
    idle();
    chk("fl_wb", 0,0,0,0, 0,0, m,m, m ? 13 : 0);
    chk("fl_done", 0,0,0,0, 0,0, 0,0, m ? 13 : 0);

    // x0 destination: ignored in RISC-V, a real register in ARM
    McStartE = 1; RdE = 0; McLatE = 3;
    chk("x0_issue", 0,0,0,0, 0,0, 0,0, m ? 13 : 0);
    idle();
    chk("x0_rv_no_stall", 0,0,0,0, 0,0, m,0, 0);
    arm = 1'b1;
    chk("x0_arm_stall", m,m,0,m, 0,0, m,0, 0);
    idle();
    chk("x0_wb", 0,0,0,0, 0,0, m,m, 0);

    // Clamping: latency 0 -> 2, latency 31 -> 16
    McStartE = 1; RdE = 3; McLatE = 0;
    chk("clamp0_issue", 0,0,0,0, 0,0, 0,0, 0);
    idle();
    for (int i = 0; i < 3; i++)
      chk($sformatf("clamp0_c%0d", i + 1), 0,0,0,0, 0,0, m && i < 2, m && i == 1, m ? 3 : 0);
    McStartE = 1; RdE = 3; McLatE = 31;
    chk("clamp31_issue", 0,0,0,0, 0,0, 0,0, m ? 3 : 0);
    idle();
    for (int i = 0; i < 17; i++)
      chk($sformatf("clamp31_c%0d", i + 1), 0,0,0,0, 0,0, m && i < 16, m && i == 15, m ? 3 : 0);

    // Reset mid-operation at cnt == 3
    McStartE = 1; RdE = 4; McLatE = 5;
    chk("rst_issue", 0,0,0,0, 0,0, 0,0, m ? 3 : 0);
    idle();
    chk("rst_c5", 0,0,0,0, 0,0, m,0, m ? 4 : 0);
    chk("rst_c4", 0,0,0,0, 0,0, m,0, m ? 4 : 0);
    reset_n = 1'b0;
    chk("rst_mid", 0,0,0,0, 0,0, 0,0, 0);
    chk("rst_hold", 0,0,0,0, 0,0, 0,0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++)
      chk($sformatf("rst_after%0d", i), 0,0,0,0, 0,0, 0,0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
